// File: rtl/regfile_reader_pkg.sv
// Shared definitions for the register-file dump streamer: default geometry
// and the FSM state encoding.
package regfile_reader_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 5;

  // One state per phase of a pair: address the pair, stream low, stream high.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_SEND_LO = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_reader.sv
// Dumps every register of a two-read-port register file as a ready/valid
// stream. Registers are fetched in even/odd pairs: both values of a pair are
// snapshotted in one READ cycle, then streamed low-then-high. A one-cycle done
// pulse follows acceptance of the final beat.
module regfile_reader
  import regfile_reader_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  localparam int                IDX_W    = ADDR_W - 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS / 2 - 1);

  state_t              state_r;
  state_t              state_s;
  logic [IDX_W-1:0]    idx_r;
  logic [DATA_W-1:0]   hold_lo_r;
  logic [DATA_W-1:0]   hold_hi_r;
  logic                last_pair_s;

  // The pair counter stops at the last pair; DONE is reached from there.
  assign last_pair_s = (idx_r == LAST_IDX);

  // State register; reset aborts any dump in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pair counter and snapshot registers for the pair being streamed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_r     <= '0;
      hold_lo_r <= '0;
      hold_hi_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            idx_r <= '0;
          end
        end
        ST_READ: begin
          hold_lo_r <= rd1;
          hold_hi_r <= rd2;
        end
        ST_SEND_HI: begin
          if (dout_ready && !last_pair_s) begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic; start only matters in IDLE, so it is never queued.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_s = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (dout_ready) begin
          state_s = ST_SEND_HI;
        end else begin
          state_s = ST_SEND_LO;
        end
      end
      ST_SEND_HI: begin
        if (!dout_ready) begin
          state_s = ST_SEND_HI;
        end else if (last_pair_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Moore output decode; everything is zero unless the state drives it, so
  // stream data stays stable under backpressure because it comes from the
  // snapshot registers.
  always_comb begin
    ra1        = '0;
    ra2        = '0;
    dout       = '0;
    dout_addr  = '0;
    dout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_READ: begin
        ra1  = {idx_r, 1'b0};
        ra2  = {idx_r, 1'b1};
        busy = 1'b1;
      end
      ST_SEND_LO: begin
        dout       = hold_lo_r;
        dout_addr  = {idx_r, 1'b0};
        dout_valid = 1'b1;
        busy       = 1'b1;
      end
      ST_SEND_HI: begin
        dout       = hold_hi_r;
        dout_addr  = {idx_r, 1'b1};
        dout_valid = 1'b1;
        busy       = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 Parameter: NUM_REGS, 32, number of registers scanned; even, power of two.
REQ-002 Parameter: DATA_W, 8, register and stream data width.
REQ-003 Parameter: ADDR_W, 5, register address width; equals log2(NUM_REGS).
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset.
REQ-006 Port: start  input  1  one-cycle request to begin a full dump.
REQ-007 Port: ra1  output  ADDR_W  register file read address 1; drives even address.
REQ-008 Port: ra2  output  ADDR_W  register file read address 2; drives odd address.
REQ-009 Port: rd1  input  DATA_W  register file read data 1; combinational from ra1.
REQ-010 Port: rd2  input  DATA_W  register file read data 2; combinational from ra2.
REQ-011 Port: dout  output  DATA_W  streamed register value.
REQ-012 Port: dout_addr  output  ADDR_W  register index of dout.
REQ-013 Port: dout_valid  output  1  dout/dout_addr valid.
REQ-014 Port: dout_ready  input  1  sink accepts beat when high with dout_valid.
REQ-015 Port: busy  output  1  dump in progress.
REQ-016 Port: done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-017 FSM states: IDLE, READ, SEND_LO, SEND_HI, DONE.
REQ-018 IDLE: start=1 -> READ, pair index cleared to 0; otherwise stay.
REQ-019 READ: ra1=2*idx, ra2=2*idx+1; rd1/rd2 captured into hold registers at the edge; -> SEND_LO.
REQ-020 SEND_LO: dout=held rd1, dout_addr=2*idx, dout_valid=1; on dout_ready -> SEND_HI.
REQ-021 SEND_HI: dout=held rd2, dout_addr=2*idx+1, dout_valid=1; on dout_ready: last pair -> DONE, else idx+1 and -> READ.
REQ-022 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-023 busy=1 in READ, SEND_LO, SEND_HI; 0 in IDLE and DONE.
REQ-024 dout and dout_addr hold stable while dout_valid=1 and dout_ready=0.
REQ-025 start ignored in every state except IDLE; no queuing.
REQ-026 Latency with dout_ready held 1: 3 cycles per pair, done asserted in cycle 3*NUM_REGS/2+1 after start.
REQ-027 Snapshot: values reflect register contents at that pair's READ cycle; later writes are not observed for that pair.
REQ-028 Pair index width is ADDR_W-1; last pair is NUM_REGS/2-1; index never wraps past last pair.
REQ-029 ra1/ra2 = 0 outside READ.

Reset
REQ-030 reset=0 at a clock edge -> IDLE, idx=0, hold registers 0, from any state including mid-dump.
REQ-031 Reset values: dout=0, dout_addr=0, dout_valid=0, busy=0, done=0, ra1=0, ra2=0.
REQ-032 start sampled during reset is discarded.

Structure
REQ-033 Shared package holds FSM state encoding and DATA_W/ADDR_W/NUM_REGS defaults used by register_file.
REQ-034 Single flat module; no sub-modules; FSM, pair counter and hold registers are local.

Verification
REQ-035 Reset: reset=0 two cycles -> all outputs 0, state IDLE.
REQ-036 Full dump: register_file r1=0xAA, r2=0x55, others 0, dout_ready=1, start pulse -> 32 beats addr 0..31, beat addr1=0xAA, addr2=0x55, addr0=0x00, done at cycle 49.
REQ-037 Backpressure: dout_ready=0 for 5 cycles at addr 1 -> dout=0xAA, dout_addr=1 held, no beat lost or repeated.
REQ-038 start pulses at cycles 4 and 20 during a dump -> ignored; exactly one done, 32 beats.
REQ-039 reset=0 while streaming addr 10 -> next cycle all outputs 0; new start restarts at addr 0.
REQ-040 Snapshot: write r3=0x3C during SEND_LO of pair 1 -> addr 3 beat shows old value; rerun shows 0x3C.
